datapath: RTL and testbench
===========================

# datapath

Datapath of the Simple RISC Machine: an 8×16-bit register file, A/B operand registers, a one-bit shifter on the B path, operand-select muxes, a four-function ALU, result register C and a registered Z/N/V status register. It sits under the CPU controller FSM, which drives every select, enable and register-number input each cycle. Results are returned through `datapath_out` and the status flags.

## Interface
- No parameters; word width fixed at 16, eight registers.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `sximm8` in 16: sign-extended 8-bit immediate, register-file write source.
- `sximm5` in 16: sign-extended 5-bit immediate, ALU B-operand source.
- `mdata` in 16: memory read data, register-file write source.
- `PC` in 16: program counter value, register-file write source.
- `vsel` in 2: write-back select. 00 `mdata`, 01 `sximm8`, 10 `PC`, 11 `datapath_out`.
- `writenum` in 3: register written.
- `write` in 1: register-file write enable.
- `readnum` in 3: register read, combinationally.
- `loada`, `loadb` in 1 each: load enables for A and B from the read port.
- `shift` in 2: shifter operation on B.
- `asel` in 1: selects Ain. 1 gives 16'h0000, 0 gives A.
- `bsel` in 1: selects Bin. 1 gives `sximm5`, 0 gives shifted B.
- `ALUop` in 2: 00 Ain+Bin, 01 Ain−Bin, 10 Ain&Bin, 11 ~Bin.
- `loadc` in 1: loads C from the ALU result.
- `loads` in 1: loads the status register.
- `datapath_out` out 16: contents of C.
- `Z_out`, `N_out`, `V_out` out 1 each: registered status flags.

## Operation
- **Write-back.** When `write`=1, R[`writenum`] is loaded with the `vsel`-selected value on the edge.
- **Read.** The read port is R[`readnum`], purely combinational. There is no write-to-read bypass: a same-cycle read returns the old value.
- **Shifter** (applied to the B register output, combinational):
  - 00: pass-through.
  - 01: shift left 1, zero fill.
  - 10: logical shift right 1, zero fill.
  - 11: arithmetic shift right 1, bit 15 replicated.
- **ALU.** All arithmetic is 16-bit two's complement, modulo 2^16, with no carry output. Subtraction is Ain + ~Bin + 1.
- **Flags**, computed from the ALU result:
  - Z = (result == 0).
  - N = result[15].
  - V = signed overflow for add (operands have the same sign and the result sign differs) and for sub (operands have different signs and the result sign differs from Ain).
  - V = 0 for AND and NOT.
- **Registers.** A, B and C each hold their value unless their enable is high. The status register holds unless `loads`=1.
- **Reset.** `reset`=1 clears A, B, C, R0–R7 and the status register to 0 on the edge. After reset, `datapath_out`=0 and Z_out=N_out=V_out=0. Reset has priority over every load and write enable.

## Timing
- Every register (R0–R7, A, B, C, status) updates only on the rising edge of `clk`.
- An operation takes one edge per stage:
  - Edge 1: register write.
  - Edge 2: A or B load.
  - Edge 3: C and status load.
  - Edge 4: write-back of C (vsel=11).
- `datapath_out` and the flags change only on the edge that loads them. All inputs must be stable before that edge.
- Simultaneous `loada` and `loadb` both capture the same R[`readnum`].
- Simultaneous `loadc` and `loads` capture the result and flags of the same ALU evaluation.
- `write` together with `vsel`=11 stores the C value from before the edge, even if `loadc` is also high.

## Structure
- Shared package holds:
  - Width constant 16.
  - Enums for `vsel` (MDATA, IMM8, PC, C).
  - Enums for `shift` (NONE, LSL, LSR, ASR).
  - Enums for `ALUop` (ADD, SUB, AND, NOTB).
- Sub-module `regfile` (8×16, one write port, one combinational read port) is instantiated as `REGFILE`. It exposes internal register signals `R0`…`R7` for hierarchical observation by benches.
- Shifter, ALU and the load-enable registers are written inline.

## Test plan
- **MOV and shifted add.** Steps: MOV R0,#7; MOV R1,#2; B←R0 with shift=01; A←R1; ALUop=00, loadc=loads=1. Required: `datapath_out`=16, Z=N=V=0. Then write back to R2 (vsel=11) and pass it through with asel=1, shift=00: `datapath_out`=16.
- **ASR and AND.** R3=16'h1E1E, R4=16'hF0F0; B←R3 with shift=11 (gives 16'h0F0F); A←R4; ALUop=10. Required: `datapath_out`=0, Z=1, N=V=0.
- **Subtract and write-back.** R1=16'h17, R2=16'h5; A←R1, B←R2; ALUop=01; write C to R3. Required: `REGFILE.R3`=16'h12, `datapath_out`=16'h12, flags 0.
- **LSL and LSR.**
  - 2 + (4 LSL 1) gives 10, flags 0.
  - 6 − (12 LSR 1) gives 0, with Z=1.
- **AND and NOT.**
  - 16'hC365 & 16'hF613 gives 16'hC201, with N=1, Z=V=0.
  - ~16'hF613 gives 16'h09EC, flags 0.
- **mdata/PC sources, overflow and reset.**
  - Writes with vsel=00 and vsel=10, inputs at 0, then add: result 0, Z=1.
  - 16'h7FFF + 1 gives V=1, N=1.
  - `reset` mid-sequence clears C and the flags on the next edge.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared types and constants for the Simple RISC Machine datapath.
package datapath_pkg;

  localparam int W = 16;

  typedef enum logic [1:0] {
    VSEL_MDATA = 2'b00,
    VSEL_IMM8  = 2'b01,
    VSEL_PC    = 2'b10,
    VSEL_C     = 2'b11
  } vsel_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_AND  = 2'b10,
    ALU_NOTB = 2'b11
  } alu_e;

endpackage

// File: rtl/datapath_if.sv
// Control/data bundle between the CPU controller (master) and the datapath (slave).
interface datapath_if;
  import datapath_pkg::*;

  logic [W-1:0] sximm8;
  logic [W-1:0] sximm5;
  logic [W-1:0] mdata;
  logic [W-1:0] PC;
  logic [1:0]   vsel;
  logic [2:0]   writenum;
  logic         write;
  logic [2:0]   readnum;
  logic         loada;
  logic         loadb;
  logic [1:0]   shift;
  logic         asel;
  logic         bsel;
  logic [1:0]   ALUop;
  logic         loadc;
  logic         loads;
  logic [W-1:0] datapath_out;
  logic         Z_out;
  logic         N_out;
  logic         V_out;

  // Control is single-cycle: every input is sampled on the rising edge it is
  // presented for; there is no valid/ready handshake on this bundle.
  modport master (
    output sximm8, sximm5, mdata, PC, vsel, writenum, write, readnum,
           loada, loadb, shift, asel, bsel, ALUop, loadc, loads,
    input  datapath_out, Z_out, N_out, V_out
  );

  modport slave (
    input  sximm8, sximm5, mdata, PC, vsel, writenum, write, readnum,
           loada, loadb, shift, asel, bsel, ALUop, loadc, loads,
    output datapath_out, Z_out, N_out, V_out
  );
endinterface

// File: rtl/datapath_regfile.sv
// 8x16 register file: one synchronous write port, one combinational read port.
module regfile
  import datapath_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_write,
  input  logic [2:0]   i_writenum,
  input  logic [W-1:0] i_wdata,
  input  logic [2:0]   i_readnum,
  output logic [W-1:0] o_rdata
);

  logic [W-1:0] r_regs [8];
  logic [W-1:0] R0, R1, R2, R3, R4, R5, R6, R7;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else if (i_write) begin
      r_regs[i_writenum] <= i_wdata;
    end
  end

  // Named copies so benches can probe REGFILE.Rn directly.
  assign R0 = r_regs[0];
  assign R1 = r_regs[1];
  assign R2 = r_regs[2];
  assign R3 = r_regs[3];
  assign R4 = r_regs[4];
  assign R5 = r_regs[5];
  assign R6 = r_regs[6];
  assign R7 = r_regs[7];

  always_comb begin
    o_rdata = R0;
    case (i_readnum)
      3'd0: o_rdata = R0;
      3'd1: o_rdata = R1;
      3'd2: o_rdata = R2;
      3'd3: o_rdata = R3;
      3'd4: o_rdata = R4;
      3'd5: o_rdata = R5;
      3'd6: o_rdata = R6;
      3'd7: o_rdata = R7;
      default: o_rdata = R0;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// SRM datapath: register file, A/B operands, B-path shifter, ALU, C result and Z/N/V status.
module datapath
  import datapath_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  datapath_if.slave bus
);

  logic [W-1:0] r_a, r_b, r_c;
  logic         r_z, r_n, r_v;

  logic [W-1:0] w_wdata, w_rdata, w_bshift, w_ain, w_bin, w_result;
  logic         w_z, w_n, w_v;

  // Write-back of C uses the registered value, so write+loadc stores the old C.
  always_comb begin
    w_wdata = bus.mdata;
    case (vsel_e'(bus.vsel))
      VSEL_MDATA: w_wdata = bus.mdata;
      VSEL_IMM8:  w_wdata = bus.sximm8;
      VSEL_PC:    w_wdata = bus.PC;
      VSEL_C:     w_wdata = r_c;
      default:    w_wdata = bus.mdata;
    endcase
  end

  regfile REGFILE (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_write    (bus.write),
    .i_writenum (bus.writenum),
    .i_wdata    (w_wdata),
    .i_readnum  (bus.readnum),
    .o_rdata    (w_rdata)
  );

  always_comb begin
    w_bshift = r_b;
    case (shift_e'(bus.shift))
      SH_NONE: w_bshift = r_b;
      SH_LSL:  w_bshift = {r_b[W-2:0], 1'b0};
      SH_LSR:  w_bshift = {1'b0, r_b[W-1:1]};
      SH_ASR:  w_bshift = {r_b[W-1], r_b[W-1:1]};
      default: w_bshift = r_b;
    endcase
  end

  assign w_ain = bus.asel ? '0 : r_a;
  assign w_bin = bus.bsel ? bus.sximm5 : w_bshift;

  always_comb begin
    w_result = '0;
    w_v      = 1'b0;
    case (alu_e'(bus.ALUop))
      ALU_ADD: begin
        w_result = w_ain + w_bin;
        w_v = (w_ain[W-1] == w_bin[W-1]) && (w_result[W-1] != w_ain[W-1]);
      end
      ALU_SUB: begin
        w_result = w_ain + ~w_bin + 16'd1;
        w_v = (w_ain[W-1] != w_bin[W-1]) && (w_result[W-1] != w_ain[W-1]);
      end
      ALU_AND:  w_result = w_ain & w_bin;
      ALU_NOTB: w_result = ~w_bin;
      default: begin
        w_result = '0;
        w_v      = 1'b0;
      end
    endcase
  end

  assign w_z = (w_result == '0);
  assign w_n = w_result[W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
      r_z <= 1'b0;
      r_n <= 1'b0;
      r_v <= 1'b0;
    end else begin
      if (bus.loada) r_a <= w_rdata;
      if (bus.loadb) r_b <= w_rdata;
      if (bus.loadc) r_c <= w_result;
      if (bus.loads) begin
        r_z <= w_z;
        r_n <= w_n;
        r_v <= w_v;
      end
    end
  end

  assign bus.datapath_out = r_c;
  assign bus.Z_out        = r_z;
  assign bus.N_out        = r_n;
  assign bus.V_out        = r_v;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the SRM datapath: hand-computed results, flags and register contents.
module tb_datapath;
  import datapath_pkg::*;

  logic clk;
  logic reset;
  datapath_if bus ();

  datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] flags();
    return {13'b0, bus.Z_out, bus.N_out, bus.V_out};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.write = 1'b0;
    bus.loada = 1'b0;
    bus.loadb = 1'b0;
    bus.loadc = 1'b0;
    bus.loads = 1'b0;
  endtask

  task automatic mov(input logic [2:0] n, input logic [15:0] v);
    bus.vsel     = VSEL_IMM8;
    bus.sximm8   = v;
    bus.writenum = n;
    bus.write    = 1'b1;
    tick();
    idle();
  endtask

  task automatic wr_src(input logic [2:0] n, input logic [1:0] vs);
    bus.vsel     = vs;
    bus.writenum = n;
    bus.write    = 1'b1;
    tick();
    idle();
  endtask

  task automatic ld_a(input logic [2:0] n);
    bus.readnum = n;
    bus.loada   = 1'b1;
    tick();
    idle();
  endtask

  task automatic ld_b(input logic [2:0] n);
    bus.readnum = n;
    bus.loadb   = 1'b1;
    tick();
    idle();
  endtask

  task automatic alu(input logic [1:0] op, input logic [1:0] sh, input logic as, input logic bs);
    bus.ALUop = op;
    bus.shift = sh;
    bus.asel  = as;
    bus.bsel  = bs;
    bus.loadc = 1'b1;
    bus.loads = 1'b1;
    tick();
    idle();
  endtask

  task automatic wb(input logic [2:0] n);
    wr_src(n, VSEL_C);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.sximm8 = '0; bus.sximm5 = '0; bus.mdata = '0; bus.PC = '0;
    bus.vsel = '0; bus.writenum = '0; bus.readnum = '0;
    bus.shift = '0; bus.asel = 1'b0; bus.bsel = 1'b0; bus.ALUop = '0;
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("reset_out", bus.datapath_out, 16'h0000);
    check("reset_flags", flags(), 16'h0000);

    // MOV and shifted add: 2 + (7 LSL 1) = 16
    mov(3'd0, 16'd7);
    mov(3'd1, 16'd2);
    ld_b(3'd0);
    ld_a(3'd1);
    alu(ALU_ADD, SH_LSL, 1'b0, 1'b0);
    check("add_lsl_out", bus.datapath_out, 16'd16);
    check("add_lsl_flags", flags(), 16'h0000);
    wb(3'd2);
    check("wb_r2", dut.REGFILE.R2, 16'd16);
    ld_b(3'd2);
    alu(ALU_ADD, SH_NONE, 1'b1, 1'b0);
    check("pass_r2", bus.datapath_out, 16'd16);

    // ASR then AND: F0F0 & 0F0F = 0
    mov(3'd3, 16'h1E1E);
    mov(3'd4, 16'hF0F0);
    ld_b(3'd3);
    ld_a(3'd4);
    alu(ALU_AND, SH_ASR, 1'b0, 1'b0);
    check("asr_and_out", bus.datapath_out, 16'h0000);
    check("asr_and_flags", flags(), 16'h0004);

    // Subtract and write-back: 0x17 - 0x5 = 0x12
    mov(3'd1, 16'h0017);
    mov(3'd2, 16'h0005);
    ld_a(3'd1);
    ld_b(3'd2);
    alu(ALU_SUB, SH_NONE, 1'b0, 1'b0);
    wb(3'd3);
    check("sub_r3", dut.REGFILE.R3, 16'h0012);
    check("sub_out", bus.datapath_out, 16'h0012);
    check("sub_flags", flags(), 16'h0000);

    // LSL: 2 + (4 LSL 1) = 10
    mov(3'd0, 16'd2);
    mov(3'd1, 16'd4);
    ld_a(3'd0);
    ld_b(3'd1);
    alu(ALU_ADD, SH_LSL, 1'b0, 1'b0);
    check("lsl_out", bus.datapath_out, 16'd10);
    check("lsl_flags", flags(), 16'h0000);

    // LSR: 6 - (12 LSR 1) = 0
    mov(3'd0, 16'd6);
    mov(3'd1, 16'd12);
    ld_a(3'd0);
    ld_b(3'd1);
    alu(ALU_SUB, SH_LSR, 1'b0, 1'b0);
    check("lsr_out", bus.datapath_out, 16'h0000);
    check("lsr_flags", flags(), 16'h0004);

    // LSR zero-fills, ASR sign-fills
    mov(3'd5, 16'h8000);
    ld_b(3'd5);
    alu(ALU_ADD, SH_LSR, 1'b1, 1'b0);
    check("lsr_fill", bus.datapath_out, 16'h4000);
    alu(ALU_ADD, SH_ASR, 1'b1, 1'b0);
    check("asr_fill", bus.datapath_out, 16'hC000);

    // AND and NOT
    mov(3'd0, 16'hC365);
    mov(3'd1, 16'hF613);
    ld_a(3'd0);
    ld_b(3'd1);
    alu(ALU_AND, SH_NONE, 1'b0, 1'b0);
    check("and_out", bus.datapath_out, 16'hC201);
    check("and_flags", flags(), 16'h0002);
    alu(ALU_NOTB, SH_NONE, 1'b0, 1'b0);
    check("not_out", bus.datapath_out, 16'h09EC);
    check("not_flags", flags(), 16'h0000);

    // sximm5 on the B path
    bus.sximm5 = 16'hFFF0;
    alu(ALU_ADD, SH_NONE, 1'b1, 1'b1);
    check("imm5_out", bus.datapath_out, 16'hFFF0);
    check("imm5_flags", flags(), 16'h0002);
    bus.sximm5 = '0;

    // mdata / PC sources
    mov(3'd5, 16'h5555);
    mov(3'd6, 16'hAAAA);
    bus.mdata = 16'h1234;
    wr_src(3'd5, VSEL_MDATA);
    check("mdata_r5", dut.REGFILE.R5, 16'h1234);
    bus.PC = 16'h0042;
    wr_src(3'd6, VSEL_PC);
    check("pc_r6", dut.REGFILE.R6, 16'h0042);
    bus.mdata = 16'h0000;
    bus.PC    = 16'h0000;
    wr_src(3'd5, VSEL_MDATA);
    wr_src(3'd6, VSEL_PC);
    ld_a(3'd5);
    ld_b(3'd6);
    alu(ALU_ADD, SH_NONE, 1'b0, 1'b0);
    check("zero_out", bus.datapath_out, 16'h0000);
    check("zero_flags", flags(), 16'h0004);

    // Overflow: 7FFF + 1 and 8000 - 1
    mov(3'd0, 16'h7FFF);
    mov(3'd1, 16'h0001);
    ld_a(3'd0);
    ld_b(3'd1);
    alu(ALU_ADD, SH_NONE, 1'b0, 1'b0);
    check("add_ovf_out", bus.datapath_out, 16'h8000);
    check("add_ovf_flags", flags(), 16'h0003);
    mov(3'd0, 16'h8000);
    ld_a(3'd0);
    alu(ALU_SUB, SH_NONE, 1'b0, 1'b0);
    check("sub_ovf_out", bus.datapath_out, 16'h7FFF);
    check("sub_ovf_flags", flags(), 16'h0001);

    // Status holds when loads=0 even though C updates
    bus.ALUop = ALU_ADD; bus.shift = SH_NONE; bus.asel = 1'b1; bus.bsel = 1'b0;
    bus.loadc = 1'b1;
    tick();
    idle();
    check("hold_out", bus.datapath_out, 16'h0001);
    check("hold_flags", flags(), 16'h0001);

    // Write-back with loadc high stores the pre-edge C
    bus.ALUop = ALU_NOTB; bus.bsel = 1'b0;
    bus.loadc    = 1'b1;
    bus.vsel     = VSEL_C;
    bus.writenum = 3'd7;
    bus.write    = 1'b1;
    tick();
    idle();
    check("wb_old_c", dut.REGFILE.R7, 16'h0001);
    check("wb_new_c", bus.datapath_out, 16'hFFFE);

    // No write-to-read bypass: A captures the old R7
    bus.vsel     = VSEL_IMM8;
    bus.sximm8   = 16'h0044;
    bus.writenum = 3'd7;
    bus.write    = 1'b1;
    bus.readnum  = 3'd7;
    bus.loada    = 1'b1;
    tick();
    idle();
    bus.sximm5 = '0;
    alu(ALU_ADD, SH_NONE, 1'b0, 1'b1);
    check("no_bypass", bus.datapath_out, 16'h0001);
    check("r7_written", dut.REGFILE.R7, 16'h0044);

    // Reset mid-sequence overrides loadc/loads/write
    mov(3'd0, 16'h8000);
    ld_a(3'd0);
    alu(ALU_ADD, SH_NONE, 1'b0, 1'b1);
    check("pre_rst_out", bus.datapath_out, 16'h8000);
    reset = 1'b1;
    bus.loadc = 1'b1; bus.loads = 1'b1; bus.write = 1'b1;
    bus.vsel = VSEL_IMM8; bus.sximm8 = 16'h00FF; bus.writenum = 3'd0;
    tick();
    reset = 1'b0;
    idle();
    check("rst_out", bus.datapath_out, 16'h0000);
    check("rst_flags", flags(), 16'h0000);
    check("rst_r0", dut.REGFILE.R0, 16'h0000);
    check("rst_r7", dut.REGFILE.R7, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
